// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps {a,b} over 00,01,10,11 into a 2-input gate and checks c against a captured truth table
// Ports: clk, rst_n (sync active-low); start/expect_tt request a sweep; a,b drive the gate, c is its result;
// busy spans the sweep, done pulses at its end; pass, err_count, fail_vec report the last completed sweep.
// Define GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN to end the sweep at the first mismatching sample.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expect_tt,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_vec
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t     state;
    logic [3:0] tt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       last;
    logic       mis;
    logic       fin;
    assign last = cnt == 4'(SETTLE_CYCLES - 1);
    assign mis  = c != tt[idx];
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
    assign fin  = last && (idx == 2'd3 || mis);
`else
    assign fin  = last && idx == 2'd3;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tt        <= 4'd0;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    tt        <= expect_tt;
                    err_count <= 3'd0;
                    fail_vec  <= 2'd0;
                    pass      <= 1'b0;
                    idx       <= 2'd0;
                    cnt       <= 4'd0;
                    {a, b}    <= 2'd0;
                    busy      <= 1'b1;
                    state     <= DRIVE;
                end
                DRIVE: if (last) begin
                    cnt <= 4'd0;
                    if (mis) begin
                        err_count <= err_count + 3'd1;
                        if (err_count == 3'd0) fail_vec <= idx;
                    end
                    if (fin) begin
                        {a, b} <= 2'd0;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
                // err_count already holds the final sample here, so pass is judged one edge after the sweep ends
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= err_count == 3'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: directed table-driven bench for gate_vector_checker at SETTLE_CYCLES 4 and 1
module tb_gate_vector_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0;
    logic       start1 = 1'b0;
    logic [3:0] expect_tt = 4'd0;
    int         gate = 0;
    logic       a4, b4, c4, busy4, done4, pass4;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [2:0] err4, err1;
    logic [1:0] fv4, fv1;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic gf(input int g, input logic x, input logic y);
        return g == 0 ? (x & y) : g == 1 ? (x | y) : g == 2 ? (x ^ y) : ~(x & y);
    endfunction

    assign c4 = gf(gate, a4, b4);
    assign c1 = gf(gate, a1, b1);

    gate_vector_checker #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expect_tt(expect_tt),
        .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .fail_vec(fv4)
    );

    gate_vector_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expect_tt(expect_tt),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fv1)
    );

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int exp_err(input int e);
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        return e != 0 ? 1 : 0;
`else
        return e;
`endif
    endfunction

    function automatic int exp_cyc(input int s, input int e, input int fv);
`ifdef GATE_VECTOR_CHECKER_STOP_ON_FAIL_EN
        return e != 0 ? (fv + 1) * s + 1 : 4 * s + 1;
`else
        return 4 * s + 1;
`endif
    endfunction

    // cyc = number of edges after the start-accepting edge until done is seen; rp>0 re-pulses start with rtt
    task automatic sweep(input bit s1, input logic [3:0] tt, input int rp, input logic [3:0] rtt, output int cyc);
        @(negedge clk);
        start4 = !s1;
        start1 = s1;
        expect_tt = tt;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start1 = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == rp) begin
                start4 = !s1;
                start1 = s1;
                expect_tt = rtt;
            end
            @(posedge clk);
            #1;
            start4 = 1'b0;
            start1 = 1'b0;
            if (s1 ? done1 : done4) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        int         g;
        logic [3:0] tt;
        int         pass;
        int         err;
        int         fv;
    } vec_t;

    vec_t vecs[8];
    int   cyc;
    int   seen;

    initial begin
        vecs[0] = '{0, 4'b1000, 1, 0, 0};
        vecs[1] = '{1, 4'b1000, 0, 2, 1};
        vecs[2] = '{2, 4'b1000, 0, 3, 1};
        vecs[3] = '{3, 4'b1000, 0, 4, 0};
        vecs[4] = '{1, 4'b1110, 1, 0, 0};
        vecs[5] = '{0, 4'b0001, 0, 2, 0};
        vecs[6] = '{3, 4'b0111, 1, 0, 0};
        vecs[7] = '{0, 4'b1100, 0, 1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", a4, 0);
        chk("rst_b", b4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_pass", pass4, 0);
        chk("rst_err", err4, 0);
        chk("rst_fv", fv4, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            gate = vecs[i].g;
            sweep(1'b0, vecs[i].tt, 0, 4'd0, cyc);
            chk($sformatf("v%0d_cyc", i), cyc, exp_cyc(4, vecs[i].err, vecs[i].fv));
            chk($sformatf("v%0d_pass", i), pass4, vecs[i].pass);
            chk($sformatf("v%0d_err", i), err4, exp_err(vecs[i].err));
            chk($sformatf("v%0d_fv", i), fv4, vecs[i].fv);
            chk($sformatf("v%0d_busy", i), busy4, 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done4, 0);
            chk($sformatf("v%0d_hold_err", i), err4, exp_err(vecs[i].err));
        end

        // start re-pulsed mid-sweep with a new table: one sweep, judged against the captured table
        gate = 1;
        sweep(1'b0, 4'b1000, 6, 4'b1110, cyc);
        chk("rp_cyc", cyc, exp_cyc(4, 2, 1));
        chk("rp_pass", pass4, 0);
        chk("rp_err", err4, exp_err(2));
        chk("rp_fv", fv4, 1);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) seen = 1;
        end
        chk("rp_single_sweep", seen, 0);

        // reset during vector 10 aborts the sweep
        gate = 0;
        @(negedge clk);
        start4 = 1'b1;
        expect_tt = 4'b1000;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_a", a4, 1);
        chk("mid_b", b4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_a", a4, 0);
        chk("abort_b", b4, 0);
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_err", err4, 0);
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done4) seen = 1;
        end
        chk("abort_no_done", seen, 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst_n = 1'b0;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        chk("prio_busy", busy4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start4 = 1'b0;
        @(posedge clk);
        #1;
        chk("prio_busy_after", busy4, 0);

        // SETTLE_CYCLES=1: one vector per cycle, done 5 edges after start acceptance
        gate = 0;
        @(negedge clk);
        start1 = 1'b1;
        expect_tt = 4'b1000;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("s1_ab%0d", k), {a1, b1}, k);
            chk($sformatf("s1_busy%0d", k), busy1, 1);
        end
        @(posedge clk);
        #1;
        chk("s1_ab_off", {a1, b1}, 0);
        chk("s1_done_early", done1, 0);
        @(posedge clk);
        #1;
        chk("s1_done_at5", done1, 1);
        chk("s1_pass", pass1, 1);
        chk("s1_err", err1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
